rf_wb_arbiter: RTL and testbench

- Drives the integer register file write port (rd address, data, write enable) as its only writer.
- Merges two result sources: single-cycle pipeline writeback (ALU, always accepted) and long-latency load/store responses (valid/ready handshake, buffered in a small FIFO).
- Keeps a 32-bit pending scoreboard so issue logic can stall on registers still awaiting a long-latency result.

---
 rtl/rf_wb_arbiter.sv | 96 +++++++++
 tb/tb_rf_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority over a DEPTH-entry
// load/store response FIFO, with a 32-bit pending scoreboard. Optional WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  input  logic        i_lsu_issue,
  input  logic [4:0]  i_lsu_issue_rd,
  input  logic        i_lsu_valid,
  output logic        o_lsu_ready,
  input  logic [4:0]  i_lsu_rd,
  input  logic [31:0] i_lsu_data,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren,
  output logic [31:0] o_pending
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          accept, take_lsu, push, pop, bypass;
  logic [31:0]   pending_nxt;

  assign o_lsu_ready = i_reset_n && (count < CW'(DEPTH));
  assign accept      = i_lsu_valid && o_lsu_ready;
  // rd==0 responses are consumed but never written
  assign take_lsu    = accept && (i_lsu_rd != 5'd0);
  assign pop         = !i_alu_valid && (count != '0);
`ifdef WB_BYPASS_EN
  assign bypass      = take_lsu && (count == '0) && !i_alu_valid;
`else
  assign bypass      = 1'b0;
`endif
  assign push        = take_lsu && !bypass;

  always_comb begin
    pending_nxt = o_pending;
    if (pop)    pending_nxt[q_rd[rd_ptr]] = 1'b0;
    if (bypass) pending_nxt[i_lsu_rd]     = 1'b0;
    // issue is applied last so a same-register set beats a clear
    if (i_lsu_issue && (i_lsu_issue_rd != 5'd0)) pending_nxt[i_lsu_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= i_lsu_rd;
      q_data[wr_ptr] <= i_lsu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      o_pending <= '0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
      o_rd_wren <= 1'b0;
    end else begin
      o_pending <= pending_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (i_alu_valid) begin
        o_rd_addr <= i_alu_rd;
        o_rd_data <= i_alu_data;
        o_rd_wren <= (i_alu_rd != 5'd0);
      end else if (pop) begin
        o_rd_addr <= q_rd[rd_ptr];
        o_rd_data <= q_data[rd_ptr];
        o_rd_wren <= 1'b1;
      end else if (bypass) begin
        o_rd_addr <= i_lsu_rd;
        o_rd_data <= i_lsu_data;
        o_rd_wren <= 1'b1;
      end else begin
        o_rd_wren <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (DEPTH=2); latency expectations
// follow WB_BYPASS_EN when defined.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_issue, lsu_valid;
  logic [4:0]  alu_rd, lsu_issue_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        lsu_ready, rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, pending;

  int total = 0;
  int bad   = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_wb_arbiter #(.DEPTH(2)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
    .i_lsu_issue(lsu_issue), .i_lsu_issue_rd(lsu_issue_rd),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
    .i_lsu_rd(lsu_rd), .i_lsu_data(lsu_data),
    .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_wren(rd_wren),
    .o_pending(pending)
  );

  always #5 clk = ~clk;

  // advance one edge; outputs are then sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_issue = 0; lsu_issue_rd = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_issue = 1'($urandom); lsu_issue_rd = 5'($urandom);
      lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      tick();
    end
    total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b exp=0", rd_wren); end
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h exp=0", pending); end
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", lsu_ready); end
    total++; if (rd_addr !== 5'd0 || rd_data !== 32'h0) begin bad++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", rd_addr, rd_data); end
    idle();
    rst_n = 1;
    #1;
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", lsu_ready); end
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    tick();
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", rd_wren, rd_addr, rd_data); end
    idle();
    tick();
    total++; if (rd_wren !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/5/deadbeef", rd_wren, rd_addr, rd_data); end
    alu_valid = 1; alu_rd = 0; alu_data = 32'h11111111;
    tick();
    total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL alu_x0 got=%b exp=0", rd_wren); end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    lsu_issue = 1; lsu_issue_rd = 7;
    tick();
    lsu_issue = 0;
    total++; if (pending !== 32'h80) begin bad++; $display("FAIL sb_set got=%h exp=00000080", pending); end
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h12345678;
    tick();
    idle();
    if (!BYP) begin
      total++; if (rd_wren !== 1'b0 || pending !== 32'h80) begin
        bad++; $display("FAIL sb_n1 got=%b/%h exp=0/00000080", rd_wren, pending); end
      tick();
    end
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h12345678) begin
      bad++; $display("FAIL sb_write got=%b/%0d/%h exp=1/7/12345678", rd_wren, rd_addr, rd_data); end
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL sb_clear got=%h exp=0", pending); end
    tick();
  endtask

  task automatic test_x0_drop();
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hBAD0BAD0;
    tick();
    idle();
    total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL x0_drop1 got=%b exp=0", rd_wren); end
    tick();
    total++; if (rd_wren !== 1'b0 || lsu_ready !== 1'b1) begin
      bad++; $display("FAIL x0_drop2 got=%b/%b exp=0/1", rd_wren, lsu_ready); end
  endtask

  task automatic test_priority();
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA1A1A1A1;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33333333;
    tick();
    lsu_rd = 4; lsu_data = 32'h44444444;
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready1 got=%b exp=1", lsu_ready); end
    tick();
    lsu_valid = 0;
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL prio_full got=%b exp=0", lsu_ready); end
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'hA1A1A1A1) begin
      bad++; $display("FAIL prio_alu got=%b/%0d/%h exp=1/1/a1a1a1a1", rd_wren, rd_addr, rd_data); end
    tick();
    total++; if (rd_addr !== 5'd1 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL prio_starve got=%0d/%b exp=1/0", rd_addr, lsu_ready); end
    idle();
    tick();
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h33333333) begin
      bad++; $display("FAIL prio_pop3 got=%b/%0d/%h exp=1/3/33333333", rd_wren, rd_addr, rd_data); end
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL prio_ready2 got=%b exp=1", lsu_ready); end
    tick();
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'h44444444) begin
      bad++; $display("FAIL prio_pop4 got=%b/%0d/%h exp=1/4/44444444", rd_wren, rd_addr, rd_data); end
    tick();
    total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL prio_empty got=%b exp=0", rd_wren); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rd   [3];
    logic [31:0] exp_data [3];
    int lat;
    exp_rd = '{5'd10, 5'd11, 5'd12};
    exp_data = '{32'hA0A0_0010, 32'hA0A0_0011, 32'hA0A0_0012};
    lat = BYP ? 1 : 2;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin lsu_valid = 1; lsu_rd = exp_rd[c]; lsu_data = exp_data[c]; end
      else idle();
      total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, lsu_ready); end
      tick();
      if (c + 1 >= lat && c + 1 - lat < 3) begin
        total++; if (rd_wren !== 1'b1 || rd_addr !== exp_rd[c+1-lat] || rd_data !== exp_data[c+1-lat]) begin
          bad++; $display("FAIL b2b_write c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rd_wren, rd_addr, rd_data,
                          exp_rd[c+1-lat], exp_data[c+1-lat]); end
      end else begin
        total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL b2b_idle c=%0d got=%b exp=0", c, rd_wren); end
      end
    end
  endtask

  task automatic test_collision();
    lsu_issue = 1; lsu_issue_rd = 9;
    tick();
    lsu_issue = 0;
    alu_valid = 1; alu_rd = 2; alu_data = 32'h22222222;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99999999;
    tick();
    lsu_valid = 0;
    alu_valid = 0;
    lsu_issue = 1; lsu_issue_rd = 9;
    tick();
    idle();
    total++; if (rd_wren !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h99999999) begin
      bad++; $display("FAIL coll_write got=%b/%0d/%h exp=1/9/99999999", rd_wren, rd_addr, rd_data); end
    total++; if (pending !== 32'h200) begin bad++; $display("FAIL coll_pending got=%h exp=00000200", pending); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 1; alu_data = 32'h0;
    lsu_issue = 1; lsu_issue_rd = 3;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h3;
    tick();
    lsu_issue_rd = 4; lsu_rd = 4; lsu_data = 32'h4;
    tick();
    idle();
    total++; if (pending !== 32'h218 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL mid_setup got=%h/%b exp=00000218/0", pending, lsu_ready); end
    rst_n = 0;
    tick();
    total++; if (rd_wren !== 1'b0 || pending !== 32'h0 || lsu_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0", rd_wren, pending, lsu_ready); end
    rst_n = 1;
    #1;
    total++; if (lsu_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", lsu_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (rd_wren !== 1'b0) begin bad++; $display("FAIL mid_nowrite i=%0d got=%b/%0d exp=0", i, rd_wren, rd_addr); end
    end
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    test_reset();
    test_alu();
    test_scoreboard();
    test_x0_drop();
    test_priority();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
